// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake plus the uart_tx data/ready/next pair.
// The arbiter takes the slave modport; the requesters and transmitter take the master side.
interface uart_tx_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8
);
   logic [NREQ-1:0]        i_req;
   logic [NREQ-1:0]        i_lock;
   logic [NREQ*DATA_W-1:0] i_data;
   logic [NREQ-1:0]        o_ack;
   logic [NREQ-1:0]        o_grant;
   logic [DATA_W-1:0]      o_tx_data;
   logic                   o_tx_ready;
   logic                   i_tx_next;

   modport slave (
      input  i_req, i_lock, i_data, i_tx_next,
      output o_ack, o_grant, o_tx_data, o_tx_ready
   );

   modport master (
      output i_req, i_lock, i_data, i_tx_next,
      input  o_ack, o_grant, o_tx_data, o_tx_ready
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin (with burst-capped locking) share of one uart_tx; ack 1 edge after request,
// byte offered only after o_next is seen, held until o_next drops or the timeout drops it.
module uart_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 65535
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   uart_tx_arbiter_if.slave        bus,
   output logic                    o_busy,
   output logic                    o_timeout,
   input  logic                    i_clr_timeout
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ARB, WAIT, OFFER} state_t;

   state_t              state_q, state_d;
   logic [LW-1:0]       last_q, last_d;
   logic                lock_q, lock_d;
   logic [BW-1:0]       burst_q, burst_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                rdy_q, rdy_d;
   logic                tout_q, tout_d;

   logic                lock_use;
   logic                go;
   logic [LW-1:0]       g;
   logic [LW:0]         rr;
   logic                fire;

   // Scanning downward leaves the requester closest after 'last' as the final hit.
   function automatic logic [LW:0] rr_pick(input logic [NREQ-1:0] req, input logic [LW-1:0] last);
      logic [LW:0] r;
      int          idx;
      r = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(last) + i) % NREQ;
         if (req[idx]) r = {1'b1, LW'(idx)};
      end
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      lock_d   = lock_q;
      burst_d  = burst_q;
      tmo_d    = tmo_q;
      ack_d    = '0;
      grant_d  = grant_q;
      data_d   = data_q;
      rdy_d    = rdy_q;
      tout_d   = tout_q;
      lock_use = lock_q && bus.i_lock[last_q] && (burst_q < BW'(MAX_BURST));
      rr       = rr_pick(bus.i_req, last_q);
      go       = lock_use ? bus.i_req[last_q] : rr[LW];
      g        = lock_use ? last_q : rr[LW-1:0];
      fire     = (tmo_q == TW'(TIMEOUT - 1));

      if (i_clr_timeout) tout_d = 1'b0;

      case (state_q)
         ARB: begin
            if (!bus.i_lock[last_q]) lock_d = 1'b0;
            if (go) begin
               data_d     = bus.i_data[g*DATA_W +: DATA_W];
               ack_d[g]   = 1'b1;
               grant_d    = '0;
               grant_d[g] = 1'b1;
               last_d     = g;
               lock_d     = bus.i_lock[g];
               burst_d    = lock_use ? ((burst_q == '1) ? burst_q : burst_q + 1'b1) : BW'(1);
               tmo_d      = '0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (fire) begin
               rdy_d   = 1'b0;
               tout_d  = 1'b1;
               state_d = ARB;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (bus.i_tx_next) begin
                  rdy_d   = 1'b1;
                  state_d = OFFER;
               end
            end
         end
         OFFER: begin
            if (fire) begin
               rdy_d   = 1'b0;
               tout_d  = 1'b1;
               state_d = ARB;
            end else begin
               tmo_d = tmo_q + 1'b1;
               // o_next falling while ready is high means uart_tx latched the byte.
               if (!bus.i_tx_next) begin
                  rdy_d   = 1'b0;
                  state_d = ARB;
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ARB;
         last_q  <= LW'(NREQ - 1);
         lock_q  <= 1'b0;
         burst_q <= '0;
         tmo_q   <= '0;
         ack_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         lock_q  <= lock_d;
         burst_q <= burst_d;
         tmo_q   <= tmo_d;
         ack_q   <= ack_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         tout_q  <= tout_d;
      end
   end

   assign bus.o_ack      = ack_q;
   assign bus.o_grant    = grant_q;
   assign bus.o_tx_data  = data_q;
   assign bus.o_tx_ready = rdy_q;
   assign o_busy         = (state_q != ARB);
   assign o_timeout      = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: byte sources, a small uart_tx behavioural model, and a ready-pulse monitor.
module tb_uart_tx_arbiter;
   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int MAXB  = 16;
   localparam int TMO   = 100;
   localparam int FRAME = 10;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   logic clr     = 1'b0;
   logic o_busy;
   logic o_timeout;
   logic u_en    = 1'b1;

   uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) bus();

   uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .MAX_BURST(MAXB), .TIMEOUT(TMO)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .bus           (bus),
      .o_busy        (o_busy),
      .o_timeout     (o_timeout),
      .i_clr_timeout (clr)
   );

   always #5 i_clk = ~i_clk;

   // uart_tx model: o_next high when idle and enabled, latches on ready&&next, then busy FRAME cycles.
   logic [4:0]  u_cnt;
   logic        u_nxt;
   logic [7:0]  tx_q[$];
   assign bus.i_tx_next = u_nxt;

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         u_cnt <= '0;
         u_nxt <= 1'b0;
      end else if (u_cnt != 0) begin
         u_cnt <= u_cnt - 1'b1;
         u_nxt <= 1'b0;
      end else if (u_nxt && bus.o_tx_ready) begin
         tx_q.push_back(bus.o_tx_data);
         u_nxt <= 1'b0;
         u_cnt <= 5'(FRAME);
      end else begin
         u_nxt <= u_en;
      end
   end

   // Monitor: ready must only rise after next was seen high; each ready pulse spans 2 cycles.
   int         rise_bad = 0;
   int         pulse_bad = 0;
   int         plen = 0;
   logic       p_rdy = 1'b0;
   logic       p_nxt = 1'b0;
   int         ack_idx_q[$];
   logic [7:0] ack_dat_q[$];

   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         plen  = 0;
         p_rdy = 1'b0;
         p_nxt = 1'b0;
      end else begin
         if (bus.o_tx_ready && !p_rdy && !p_nxt) rise_bad++;
         if (bus.o_tx_ready) plen++;
         else begin
            if (p_rdy && plen != 2) pulse_bad++;
            plen = 0;
         end
         for (int k = 0; k < NREQ; k++) begin
            if (bus.o_ack[k]) begin
               ack_idx_q.push_back(k);
               ack_dat_q.push_back(bus.o_tx_data);
            end
         end
         p_rdy = bus.o_tx_ready;
         p_nxt = bus.i_tx_next;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      i_rst_n    = 1'b0;
      bus.i_req  = '0;
      bus.i_lock = '0;
      bus.i_data = '0;
      clr        = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   // Runs continuous requests until n acks, drains the wire, and checks order/payload.
   task automatic run_stream(input string nm, input int n, input int exp_idx[$], input logic [7:0] exp_dat[$]);
      int ab, tb0, rb, pb, cyc;
      ab  = ack_idx_q.size();
      tb0 = tx_q.size();
      rb  = rise_bad;
      pb  = pulse_bad;
      cyc = 0;
      while (ack_idx_q.size() - ab < n && cyc < 3000) begin
         @(negedge i_clk);
         cyc++;
      end
      bus.i_req  = '0;
      bus.i_lock = '0;
      chk({nm, "_acks"}, ack_idx_q.size() - ab, n);
      cyc = 0;
      while (tx_q.size() - tb0 < n && cyc < 300) begin
         @(negedge i_clk);
         cyc++;
      end
      chk({nm, "_bytes"}, tx_q.size() - tb0, n);
      for (int i = 0; i < n; i++) begin
         if (ab + i < ack_idx_q.size()) begin
            chk($sformatf("%s_idx%0d", nm, i), ack_idx_q[ab+i], exp_idx[i]);
            chk($sformatf("%s_ackdat%0d", nm, i), ack_dat_q[ab+i], exp_dat[i]);
         end
         if (tb0 + i < tx_q.size())
            chk($sformatf("%s_wire%0d", nm, i), tx_q[tb0+i], exp_dat[i]);
      end
      chk({nm, "_early_rise"}, rise_bad - rb, 0);
      chk({nm, "_pulse_len"}, pulse_bad - pb, 0);
      repeat (20) @(negedge i_clk);
   endtask

   initial begin
      int         ei[$];
      logic [7:0] ed[$];
      int         t0;

      // reset state
      u_en = 1'b1;
      i_rst_n = 1'b0;
      bus.i_req = '0; bus.i_lock = '0; bus.i_data = '0;
      #1;
      chk("rst_outs", {bus.o_ack, bus.o_grant, bus.o_tx_data, bus.o_tx_ready, o_busy, o_timeout}, 0);
      do_reset();
      chk("rst_rel_outs", {bus.o_ack, bus.o_grant, bus.o_tx_data, bus.o_tx_ready, o_busy, o_timeout}, 0);

      // single requester, uart idle
      t0 = tx_q.size();
      bus.i_req[0] = 1'b1;
      bus.i_data[7:0] = 8'h41;
      @(negedge i_clk);
      chk("s_ack_e1", bus.o_ack, 4'b0001);
      chk("s_grant_e1", bus.o_grant, 4'b0001);
      chk("s_rdy_e1", bus.o_tx_ready, 0);
      chk("s_data_e1", bus.o_tx_data, 8'h41);
      chk("s_busy_e1", o_busy, 1);
      bus.i_req = '0;
      @(negedge i_clk);
      chk("s_ack_e2", bus.o_ack, 4'b0000);
      chk("s_rdy_e2", bus.o_tx_ready, 1);
      @(negedge i_clk);
      chk("s_rdy_e3", bus.o_tx_ready, 1);
      chk("s_latched_e3", tx_q.size() - t0, 1);
      @(negedge i_clk);
      chk("s_rdy_e4", bus.o_tx_ready, 0);
      chk("s_busy_e4", o_busy, 0);
      if (tx_q.size() > t0) chk("s_wire", tx_q[t0], 8'h41);
      chk("s_tout", o_timeout, 0);
      chk("s_grant_hold", bus.o_grant, 4'b0001);

      // round-robin, all four requesting
      do_reset();
      ei = {}; ed = {};
      for (int i = 0; i < 8; i++) begin
         ei.push_back(i % 4);
         ed.push_back(8'h10 + 8'(i % 4));
      end
      bus.i_data = {8'h13, 8'h12, 8'h11, 8'h10};
      bus.i_req  = 4'b1111;
      run_stream("rr", 8, ei, ed);

      // back-to-back with a sparse pattern (0 and 2)
      do_reset();
      ei = {}; ed = {};
      for (int i = 0; i < 6; i++) begin
         ei.push_back((i % 2) * 2);
         ed.push_back((i % 2) ? 8'hC2 : 8'hA0);
      end
      bus.i_data = {8'h00, 8'hC2, 8'h00, 8'hA0};
      bus.i_req  = 4'b0101;
      run_stream("b2b", 6, ei, ed);

      // lock with burst cap: 16 to req1, one to req2, then req1 again
      do_reset();
      ei = {}; ed = {};
      for (int i = 0; i < 21; i++) begin
         ei.push_back(i == 16 ? 2 : 1);
         ed.push_back(i == 16 ? 8'h22 : 8'h21);
      end
      bus.i_data = {8'h00, 8'h22, 8'h21, 8'h00};
      bus.i_lock = 4'b0010;
      bus.i_req  = 4'b0110;
      run_stream("lock", 21, ei, ed);

      // timeout with transmitter disabled; first grant after reset wraps to requester 3
      u_en = 1'b0;
      do_reset();
      t0 = tx_q.size();
      bus.i_req[3] = 1'b1;
      bus.i_data[31:24] = 8'h5A;
      @(negedge i_clk);
      chk("t_grant", bus.o_grant, 4'b1000);
      chk("t_data", bus.o_tx_data, 8'h5A);
      bus.i_req = '0;
      repeat (99) @(negedge i_clk);
      chk("t_tout_c99", o_timeout, 0);
      chk("t_busy_c99", o_busy, 1);
      @(negedge i_clk);
      chk("t_tout_c100", o_timeout, 1);
      chk("t_rdy_c100", bus.o_tx_ready, 0);
      chk("t_busy_c100", o_busy, 0);
      clr = 1'b1;
      @(negedge i_clk);
      chk("t_clr", o_timeout, 0);
      bus.i_req[3] = 1'b1;
      bus.i_data[31:24] = 8'h5B;
      @(negedge i_clk);
      chk("t2_grant", bus.o_ack, 4'b1000);
      bus.i_req = '0;
      repeat (99) @(negedge i_clk);
      chk("t2_tout_c99", o_timeout, 0);
      @(negedge i_clk);
      chk("t2_fire_beats_clr", o_timeout, 1);
      @(negedge i_clk);
      chk("t2_clr_after", o_timeout, 0);
      clr = 1'b0;
      chk("t_no_bytes", tx_q.size() - t0, 0);

      // reset during OFFER
      u_en = 1'b1;
      do_reset();
      bus.i_req[2] = 1'b1;
      bus.i_data[23:16] = 8'h77;
      @(negedge i_clk);
      chk("m_ack", bus.o_ack, 4'b0100);
      @(negedge i_clk);
      chk("m_offer_rdy", bus.o_tx_ready, 1);
      i_rst_n = 1'b0;
      #1;
      chk("m_async_outs", {bus.o_ack, bus.o_grant, bus.o_tx_data, bus.o_tx_ready, o_busy, o_timeout}, 0);
      bus.i_req = 4'b0101;
      bus.i_data[7:0] = 8'h30;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("m_first_grant", bus.o_grant, 4'b0001);
      chk("m_first_data", bus.o_tx_data, 8'h30);
      bus.i_req = '0;
      repeat (30) @(negedge i_clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
